// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: datapath widths,
// load type codes and register constants.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LBU  = 3'd2;
  localparam logic [2:0] LT_LH   = 3'd3;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_LW   = 3'd5;
  localparam logic [2:0] LT_LWL  = 3'd6;
  localparam logic [2:0] LT_LWR  = 3'd7;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  function automatic logic [31:0] sext8(
    input logic [7:0] b
  );
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(
    input logic [15:0] h
  );
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian load data extraction and
// LWL/LWR merge for the writeback stage.
module load_align
  import cpu_defs::*;
(
  input  logic [2:0]  ltype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  input  logic [31:0] result,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lwl_w;
  logic [31:0] lwr_w;

  // lane 0 is the most significant byte
  always_comb begin
    lane_b = rdata[31:24];
    unique case (addr_lo)
      2'd0: lane_b = rdata[31:24];
      2'd1: lane_b = rdata[23:16];
      2'd2: lane_b = rdata[15:8];
      2'd3: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[15:0]
                        : rdata[31:16];
  end

  // partial-word merges with old rt
  always_comb begin
    lwl_w = rdata;
    lwr_w = rdata;
    unique case (addr_lo)
      2'd0: begin
        lwl_w = rdata;
        lwr_w = {rt[31:8], rdata[31:24]};
      end
      2'd1: begin
        lwl_w = {rdata[23:0], rt[7:0]};
        lwr_w = {rt[31:16], rdata[31:16]};
      end
      2'd2: begin
        lwl_w = {rdata[15:0], rt[15:0]};
        lwr_w = {rt[31:24], rdata[31:8]};
      end
      2'd3: begin
        lwl_w = {rdata[7:0], rt[23:0]};
        lwr_w = rdata;
      end
    endcase
  end

  // select by load type and flag bad alignment
  always_comb begin
    data       = result;
    misaligned = 1'b0;
    unique case (ltype)
      LT_NONE: data = result;
      LT_LB:   data = sext8(lane_b);
      LT_LBU:  data = {24'd0, lane_b};
      LT_LH: begin
        data       = sext16(lane_h);
        misaligned = addr_lo[0];
      end
      LT_LHU: begin
        data       = {16'd0, lane_h};
        misaligned = addr_lo[0];
      end
      LT_LW: begin
        data       = rdata;
        misaligned = (addr_lo != 2'd0);
      end
      LT_LWL:  data = lwl_w;
      LT_LWR:  data = lwr_w;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB stage register: aligned load data,
// register write port and retired counter.
module mem_wb
  import cpu_defs::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_waddr,
  input  logic          mem_we,
  input  logic [2:0]    mem_ltype,
  input  logic [DW-1:0] mem_result,
  input  logic [1:0]    mem_addr_lo,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] mem_rt,
  input  logic          stall,
  input  logic          flush,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_we,
  output logic          wb_align_err,
  output logic [31:0]   retired
);

  logic [31:0] al_data;
  logic        al_mis;
  logic        cap;
  logic        we_n;

  load_align u_align (
    .ltype      (mem_ltype),
    .addr_lo    (mem_addr_lo),
    .rdata      (mem_rdata[31:0]),
    .rt         (mem_rt[31:0]),
    .result     (mem_result[31:0]),
    .data       (al_data),
    .misaligned (al_mis)
  );

  assign cap  = mem_valid & ~stall & ~flush;
  assign we_n = mem_we & cap & ~al_mis
              & (mem_waddr != AW'(REG_ZERO));

  // stage register; anything not captured is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_waddr     <= '0;
      wb_wdata     <= '0;
      wb_we        <= 1'b0;
      wb_align_err <= 1'b0;
    end else if (cap) begin
      wb_waddr     <= mem_waddr;
      wb_wdata     <= DW'(al_data);
      wb_we        <= we_n;
      wb_align_err <= al_mis;
    end else begin
      wb_waddr     <= '0;
      wb_wdata     <= '0;
      wb_we        <= 1'b0;
      wb_align_err <= 1'b0;
    end
  end

  // count every captured instruction, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      retired <= '0;
    else if (cap) retired <= retired + 32'd1;
  end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb with a shift/mask
// reference model and per-cycle comparison.
module tb_mem_wb;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_waddr = '0;
  logic        mem_we = 1'b0;
  logic [2:0]  mem_ltype = LT_NONE;
  logic [31:0] mem_result = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_rt = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_align_err;
  logic [31:0] retired;

  int passed = 0;
  int total  = 0;

  logic [4:0]  e_waddr = '0;
  logic [31:0] e_wdata = '0;
  logic        e_we = 1'b0;
  logic        e_err = 1'b0;
  logic [31:0] e_ret = '0;
  logic        run = 1'b1;

  mem_wb dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_waddr    (mem_waddr),
    .mem_we       (mem_we),
    .mem_ltype    (mem_ltype),
    .mem_result   (mem_result),
    .mem_addr_lo  (mem_addr_lo),
    .mem_rdata    (mem_rdata),
    .mem_rt       (mem_rt),
    .stall        (stall),
    .flush        (flush),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .wb_we        (wb_we),
    .wb_align_err (wb_align_err),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] m_align(
    input logic [2:0]  lt,
    input logic [1:0]  lo,
    input logic [31:0] rd,
    input logic [31:0] rt,
    input logic [31:0] res
  );
    int n;
    logic [63:0] mask;
    logic [7:0]  b;
    logic [15:0] h;
    n = int'(lo);
    b = 8'(rd >> (8 * (3 - n)));
    h = 16'(rd >> (lo[1] ? 0 : 16));
    case (lt)
      LT_LB:  return {{24{b[7]}}, b};
      LT_LBU: return {24'd0, b};
      LT_LH:  return {{16{h[15]}}, h};
      LT_LHU: return {16'd0, h};
      LT_LW:  return rd;
      LT_LWL: begin
        mask = (64'd1 << (8 * n)) - 64'd1;
        return (rd << (8 * n))
             | (rt & mask[31:0]);
      end
      LT_LWR: begin
        mask = (64'd1 << (8 * (n + 1))) - 64'd1;
        return (rt & ~mask[31:0])
             | (rd >> (8 * (3 - n)));
      end
      default: return res;
    endcase
  endfunction

  function automatic logic m_mis(
    input logic [2:0] lt,
    input logic [1:0] lo
  );
    if (lt == LT_LH || lt == LT_LHU)
      return lo[0];
    if (lt == LT_LW)
      return lo != 2'd0;
    return 1'b0;
  endfunction

  // reference model of the registered outputs
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_waddr = '0; e_wdata = '0;
      e_we = 0; e_err = 0; e_ret = '0;
    end else if (mem_valid && !stall && !flush) begin
      e_waddr = mem_waddr;
      e_err   = m_mis(mem_ltype, mem_addr_lo);
      e_wdata = m_align(mem_ltype, mem_addr_lo,
                        mem_rdata, mem_rt,
                        mem_result);
      e_we    = mem_we && mem_waddr != 0
             && !e_err;
      e_ret   = e_ret + 1;
    end else begin
      e_waddr = '0; e_wdata = '0;
      e_we = 0; e_err = 0;
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (run) begin
      chk("m_we", 32'(wb_we), 32'(e_we));
      chk("m_err", 32'(wb_align_err),
          32'(e_err));
      chk("m_waddr", 32'(wb_waddr),
          32'(e_waddr));
      if (!e_err)
        chk("m_wdata", wb_wdata, e_wdata);
      chk("m_ret", retired, e_ret);
    end
  end

  task automatic step(
    input logic        v,
    input logic [4:0]  wa,
    input logic        we,
    input logic [2:0]  lt,
    input logic [31:0] res,
    input logic [1:0]  lo,
    input logic [31:0] rd,
    input logic [31:0] rt,
    input logic        st,
    input logic        fl
  );
    @(negedge clk);
    mem_valid = v;  mem_waddr = wa;
    mem_we = we;    mem_ltype = lt;
    mem_result = res; mem_addr_lo = lo;
    mem_rdata = rd; mem_rt = rt;
    stall = st;     flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0]  lt,
                    input logic [1:0]  lo,
                    input logic [31:0] rd,
                    input logic [31:0] rt);
    step(1, 5'd9, 1, lt, 32'hDEAD0000,
         lo, rd, rt, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_valid = 0; stall = 0; flush = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  logic [31:0] r0;

  initial begin
    #2;
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_ret", retired, 0);
    @(negedge clk);
    rst = 0;

    step(1, 5'd5, 1, LT_NONE, 32'hAA,
         0, 0, 0, 0, 0);
    chk("pre_we", 32'(wb_we), 1);
    #2 rst = 1;
    #1;
    chk("arst_we", 32'(wb_we), 0);
    chk("arst_wd", wb_wdata, 0);
    chk("arst_wa", 32'(wb_waddr), 0);
    chk("arst_ret", retired, 0);
    @(negedge clk);
    mem_valid = 0;
    rst = 0;
    step(1, 5'd3, 1, LT_NONE, 32'h1234,
         0, 0, 0, 0, 0);
    chk("first_we", 32'(wb_we), 1);
    chk("first_wa", 32'(wb_waddr), 3);
    chk("first_wd", wb_wdata, 32'h1234);

    ld(LT_LB, 0, 32'h80FF7F01, 0);
    chk("lb0", wb_wdata, 32'hFFFFFF80);
    ld(LT_LBU, 1, 32'h80FF7F01, 0);
    chk("lbu1", wb_wdata, 32'h000000FF);
    ld(LT_LB, 2, 32'h80FF7F01, 0);
    chk("lb2", wb_wdata, 32'h0000007F);
    ld(LT_LH, 2, 32'h1234ABCD, 0);
    chk("lh2", wb_wdata, 32'hFFFFABCD);
    ld(LT_LHU, 1, 32'h1234ABCD, 0);
    chk("lhu1_we", 32'(wb_we), 0);
    chk("lhu1_err", 32'(wb_align_err), 1);
    ld(LT_LWL, 1, 32'hAABBCCDD, 32'h11223344);
    chk("lwl1", wb_wdata, 32'hBBCCDD44);
    ld(LT_LWR, 1, 32'hAABBCCDD, 32'h11223344);
    chk("lwr1", wb_wdata, 32'h1122AABB);
    ld(LT_LWL, 0, 32'hAABBCCDD, 32'h11223344);
    chk("lwl0", wb_wdata, 32'hAABBCCDD);
    ld(LT_LWR, 3, 32'hAABBCCDD, 32'h11223344);
    chk("lwr3", wb_wdata, 32'hAABBCCDD);
    chk("lwr3_err", 32'(wb_align_err), 0);

    r0 = retired;
    step(1, 5'd0, 1, LT_NONE, 32'h55,
         0, 0, 0, 0, 0);
    chk("r0_we", 32'(wb_we), 0);
    chk("r0_ret", retired, r0 + 1);

    do_reset();
    step(1, 5'd1, 1, LT_NONE, 32'h10,
         0, 0, 0, 0, 0);
    chk("sf_c0", 32'(wb_we), 1);
    step(1, 5'd2, 1, LT_NONE, 32'h20,
         0, 0, 0, 1, 0);
    chk("sf_c1", 32'(wb_we), 0);
    step(1, 5'd3, 1, LT_NONE, 32'h30,
         0, 0, 0, 1, 1);
    chk("sf_c2", 32'(wb_we), 0);
    step(1, 5'd4, 1, LT_NONE, 32'h40,
         0, 0, 0, 0, 0);
    chk("sf_c3", 32'(wb_we), 1);
    chk("sf_ret", retired, 2);

    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 3) != 0,
           5'($urandom), $urandom_range(0, 1) != 0,
           3'($urandom), $urandom,
           2'($urandom), $urandom, $urandom,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0);

    @(negedge clk);
    mem_valid = 0;
    force dut.retired = 32'hFFFFFFFF;
    #1 release dut.retired;
    e_ret = 32'hFFFFFFFF;
    step(1, 5'd7, 1, LT_NONE, 32'h1,
         0, 0, 0, 0, 0);
    chk("wrap", retired, 0);

    @(negedge clk);
    run = 0;
    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
# mem_wb

Memory-to-writeback pipeline stage of the five-stage MIPS core. It registers each instruction leaving MEM and performs big-endian load data extraction (LB/LBU/LH/LHU/LW/LWL/LWR). It drives the register file write port (`wb_waddr`, `wb_wdata`, `wb_we`) directly from flops, one cycle after MEM. It also handles stall/flush bubbles and keeps a retired-instruction counter.

## Interface
Parameters:
- `DW`, 32: datapath width.
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  MEM slot holds a real instruction.
- `mem_waddr`  in  AW  destination register.
- `mem_we`  in  1  instruction writes a register.
- `mem_ltype`  in  3  load type code; `LT_NONE` means write `mem_result`.
- `mem_result`  in  DW  ALU/move result.
- `mem_addr_lo`  in  2  data address bits [1:0].
- `mem_rdata`  in  DW  data memory read word, valid in the same cycle.
- `mem_rt`  in  DW  old rt value, used for LWL/LWR merge.
- `stall`  in  1  MEM stage held this cycle.
- `flush`  in  1  kill the MEM-stage instruction.
- `wb_waddr`  out  AW  register file write address.
- `wb_wdata`  out  DW  register file write data.
- `wb_we`  out  1  register file write enable.
- `wb_align_err`  out  1  misaligned LH/LHU/LW captured; one-cycle pulse.
- `retired`  out  32  count of non-bubble instructions captured.

## Operation
- Capture condition: `cap = mem_valid & ~stall & ~flush`.
  - On `cap`, the stage register loads the aligned data and control.
  - Otherwise it loads a bubble: `wb_we=0`, `wb_waddr=0`, `wb_wdata=0`, `wb_align_err=0`.
  - A stalled MEM instruction therefore is never written twice.
- `flush` has priority over `stall`. Both produce a bubble, and `retired` is not incremented.
- `wb_we` is registered as `mem_we & cap & (mem_waddr != 0) & ~misaligned`. A write to $0 never asserts `wb_we`.
- Alignment is big-endian: byte lane k = `mem_addr_lo` selects `mem_rdata[31-8k -: 8]`.
  - LB: sign-extend the lane byte. LBU: zero-extend it.
  - LH/LHU: the half at lane (`addr_lo[1]`*2), sign- or zero-extended.
  - LW: the word unchanged.
  - LWL, addr_lo = n: `{mem_rdata[31-8n:0], mem_rt[8n-1:0]}`; n=0 gives the full word.
  - LWR, addr_lo = n: `{mem_rt[31:8(n+1)], mem_rdata[31:8(3-n)]}`; n=3 gives the full word.
- Misaligned cases: LH/LHU with `addr_lo[0]=1`, or LW with `addr_lo != 0`. The stage captures with `wb_we=0` and `wb_align_err=1`. The exception itself is raised upstream; this output is a checker aid.
- `retired` increments by 1 on every `cap`, including non-writing instructions. It wraps modulo 2^32 from 0xFFFFFFFF to 0.

## Timing
- Latency is 1 cycle from MEM inputs to `wb_*` outputs. All outputs come straight from flops, with no combinational input-to-output path. This protects the register file's same-cycle write-bypass path.
- Reset values: `wb_waddr=0`, `wb_wdata=0`, `wb_we=0`, `wb_align_err=0`, `retired=0`.
- Reset asserted mid-stream clears the registers immediately, without waiting for a clock edge. The first capture after release happens on the first rising edge with `rst=0` and `cap=1`.
- `stall` and `flush` are sampled on the same edge as the data. A one-cycle `stall` yields exactly one bubble cycle on `wb_we`.
- There is no back-pressure from the register file; it accepts a write every cycle.

## Structure
- Shared package `cpu_defs`:
  - `LT_NONE=3'd0`, `LT_LB=1`, `LT_LBU=2`, `LT_LH=3`, `LT_LHU=4`, `LT_LW=5`, `LT_LWL=6`, `LT_LWR=7`.
  - `REG_ZERO=5'd0`.
  - Data and register-address width constants shared with decode and the register file.
- One combinational sub-module, `load_align`:
  - Inputs: `ltype`, `addr_lo`, `rdata`, `rt`, `result`.
  - Outputs: `data`, `misaligned`.
  - Instantiated before the stage register.
- The stage register and the `retired` counter live in `mem_wb`.

## Test plan
- Reset: assert `rst` mid-stream with `wb_we=1` → all outputs 0 immediately. After release, the first valid ALU write (waddr=3, result=0x1234) appears next cycle with `wb_we=1`.
- Byte loads: `mem_rdata=0x80FF7F01`.
  - LB addr_lo=0 → 0xFFFFFF80.
  - LBU addr_lo=1 → 0x000000FF.
  - LB addr_lo=2 → 0x0000007F.
- Halfword loads:
  - LH addr_lo=2, `mem_rdata=0x1234ABCD` → 0xFFFFABCD.
  - LHU addr_lo=1 → `wb_we=0`, `wb_align_err=1`.
- Unaligned word merge: `mem_rdata=0xAABBCCDD`, `mem_rt=0x11223344`.
  - LWL addr_lo=1 → 0xBBCCDD44.
  - LWR addr_lo=1 → 0x1122AABB.
  - LWL n=0 and LWR n=3 → 0xAABBCCDD.
- Stall/flush:
  - Valid writes on cycles 0–3 with `stall` at cycle 1 and `flush` at cycle 2 → `wb_we` high only for cycles 0 and 3, and `retired` ends at 2.
  - A write to waddr=0 → `wb_we=0`, `retired` still increments.
- Counter wrap: force `retired` to 0xFFFFFFFF, then one capture → `retired` = 0.
